// File: rtl/minute_hour_pkg.sv
// Shared clock constants for the seconds/minutes/hours chain.
// Field limits and widths are kept here so every stage agrees on them.
package minute_hour_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

    typedef enum logic {
        SEL_MIN  = 1'b0,
        SEL_HOUR = 1'b1
    } load_sel_e;

endpackage

// File: rtl/minute_hour_counter.sv
// Modulo-(MAX+1) counter with synchronous clear, load and increment.
// wrap flags an increment taken while at MAX, so stages can be chained.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Initialised so power-up matches the seconds stage without a reset pulse.
    logic [W-1:0] count_r = '0;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= data;
        end else if (inc) begin
            count_r <= (count_r == MAX_V) ? '0 : count_r + W'(1);
        end
    end

    assign count = count_r;
    assign wrap  = inc & (count_r == MAX_V);

endmodule

// File: rtl/minute_hour.sv
// Minute/hour stage of the clock: counts on the seconds carry, accepts
// per-field loads, and presents either a 24-hour or 12-hour+pm view.
module minute_hour
    import minute_hour_pkg::*;
#(
    parameter int H24 = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        tick,
    input  logic [5:0]  sec,
    input  logic        load,
    input  logic        load_sel,
    input  logic [5:0]  data,
    input  logic        enable,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic        pm,
    output logic        day_carry,
    output logic [11:0] databus
);

    logic              cin;
    logic              cnt_en;
    logic              min_ok;
    logic              hour_ok;
    logic              min_load;
    logic              hour_load;
    logic              min_wrap;
    logic              hour_wrap;
    logic [MIN_W-1:0]  min_r;
    logic [HOUR_W-1:0] hour_r;
    logic              day_carry_r = 1'b0;
    logic [4:0]        hour_disp;
    logic              pm_disp;

    // Any load request, valid or not, swallows this cycle's count advance.
    assign cin       = tick & (sec == 6'(SEC_MAX));
    assign cnt_en    = cin & ~load;
    assign min_ok    = (data <= 6'(MIN_MAX));
    assign hour_ok   = (data <= 6'(HOUR_MAX));
    assign min_load  = load & (load_sel == SEL_MIN)  & min_ok;
    assign hour_load = load & (load_sel == SEL_HOUR) & hour_ok;

    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .clear (clear),
        .inc   (cnt_en),
        .load  (min_load),
        .data  (data),
        .count (min_r),
        .wrap  (min_wrap)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk   (clk),
        .clear (clear),
        .inc   (min_wrap),
        .load  (hour_load),
        .data  (data[4:0]),
        .count (hour_r),
        .wrap  (hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            day_carry_r <= 1'b0;
        end else begin
            day_carry_r <= hour_wrap;
        end
    end

    // 12-hour view: midnight and noon both read 12, afternoon folds down by 12.
    always_comb begin
        hour_disp = hour_r;
        pm_disp   = 1'b0;
        if (H24 == 0) begin
            pm_disp = (hour_r >= 5'd12);
            if (hour_r == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_r > 5'd12) begin
                hour_disp = hour_r - 5'd12;
            end
        end
    end

    assign min       = min_r;
    assign hour      = hour_disp;
    assign pm        = pm_disp;
    assign day_carry = day_carry_r;
    assign databus   = {pm_disp, hour_disp, min_r} & {12{enable}};

endmodule

// File: tb/tb_minute_hour.sv
// Self-checking bench for minute_hour: runs a 24-hour and a 12-hour instance
// side by side against directed vectors and a minutes-of-day reference model.
module tb_minute_hour;

    logic        clk;
    logic        clear;
    logic        tick;
    logic [5:0]  sec;
    logic        load;
    logic        load_sel;
    logic [5:0]  data;
    logic        enable;

    logic [5:0]  min24, min12;
    logic [4:0]  hour24, hour12;
    logic        pm24, pm12;
    logic        dc24, dc12;
    logic [11:0] bus24, bus12;

    int checks   = 0;
    int failures = 0;

    // Reference state: minutes since midnight plus the expected carry pulse.
    int modelT  = 0;
    bit modelDc = 0;

    typedef struct {
        string     name;
        bit        clr;
        bit        tck;
        bit [5:0]  sc;
        bit        ld;
        bit        sel;
        bit [5:0]  dat;
        bit        en;
        int        expMin;
        int        expHour;
        bit        expDc;
    } vec_t;

    vec_t vecs[$];

    minute_hour #(.H24(1)) dut24 (
        .clk       (clk),
        .clear     (clear),
        .tick      (tick),
        .sec       (sec),
        .load      (load),
        .load_sel  (load_sel),
        .data      (data),
        .enable    (enable),
        .min       (min24),
        .hour      (hour24),
        .pm        (pm24),
        .day_carry (dc24),
        .databus   (bus24)
    );

    minute_hour #(.H24(0)) dut12 (
        .clk       (clk),
        .clear     (clear),
        .tick      (tick),
        .sec       (sec),
        .load      (load),
        .load_sel  (load_sel),
        .data      (data),
        .enable    (enable),
        .min       (min12),
        .hour      (hour12),
        .pm        (pm12),
        .day_carry (dc12),
        .databus   (bus12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(string name, bit clr, bit tck, bit [5:0] sc,
                                   bit ld, bit sel, bit [5:0] dat, bit en,
                                   int expMin, int expHour, bit expDc);
        vec_t v;
        v.name = name; v.clr = clr; v.tck = tck; v.sc = sc;
        v.ld = ld; v.sel = sel; v.dat = dat; v.en = en;
        v.expMin = expMin; v.expHour = expHour; v.expDc = expDc;
        vecs.push_back(v);
    endfunction

    function automatic void cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic applyStimulus(bit clr, bit tck, bit [5:0] sc, bit ld,
                                 bit sel, bit [5:0] dat, bit en);
        clear    = clr;
        tick     = tck;
        sec      = sc;
        load     = ld;
        load_sel = sel;
        data     = dat;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    // Expected views are derived from the 24-hour value with plain arithmetic.
    task automatic checkOutput(string name, int expMin, int expHour, bit expDc);
        int h12;
        int expPm;
        int en;
        h12   = (expHour % 12 == 0) ? 12 : expHour % 12;
        expPm = (expHour >= 12) ? 1 : 0;
        en    = enable ? 1 : 0;
        cmp({name, ".min24"},  min24,  expMin);
        cmp({name, ".hour24"}, hour24, expHour);
        cmp({name, ".pm24"},   pm24,   0);
        cmp({name, ".dc24"},   dc24,   expDc);
        cmp({name, ".bus24"},  bus24,  en * (expHour * 64 + expMin));
        cmp({name, ".min12"},  min12,  expMin);
        cmp({name, ".hour12"}, hour12, h12);
        cmp({name, ".pm12"},   pm12,   expPm);
        cmp({name, ".dc12"},   dc12,   expDc);
        cmp({name, ".bus12"},  bus12,  en * (expPm * 2048 + h12 * 64 + expMin));
    endtask

    function automatic void modelStep(bit clr, bit tck, bit [5:0] sc, bit ld,
                                      bit sel, bit [5:0] dat);
        if (clr) begin
            modelT  = 0;
            modelDc = 0;
        end else if (ld) begin
            modelDc = 0;
            if (!sel && dat <= 59)
                modelT = (modelT / 60) * 60 + int'(dat);
            else if (sel && dat <= 23)
                modelT = int'(dat) * 60 + modelT % 60;
        end else if (tck && sc == 59) begin
            modelDc = (modelT == 1439);
            modelT  = (modelT + 1) % 1440;
        end else begin
            modelDc = 0;
        end
    endfunction

    initial begin
        clear = 1'b0; tick = 1'b0; sec = '0; load = 1'b0;
        load_sel = 1'b0; data = '0; enable = 1'b1;

        //     name          clr tck sec ld sel dat en  min hr dc
        addVec("rst0",       1,  0,  0,  0, 0,  0, 1,   0, 0, 0);
        addVec("ldmin37",    0,  0,  0,  1, 0, 37, 1,  37, 0, 0);
        addVec("ldhr14",     0,  0,  0,  1, 1, 14, 1,  37,14, 0);
        addVec("clr",        1,  1, 59,  1, 1,  5, 1,   0, 0, 0);
        addVec("ldmin5",     0,  0,  0,  1, 0,  5, 1,   5, 0, 0);
        addVec("tick59",     0,  1, 59,  0, 0,  0, 1,   6, 0, 0);
        addVec("tick58",     0,  1, 58,  0, 0,  0, 1,   6, 0, 0);
        addVec("sec63",      0,  1, 63,  0, 0,  0, 1,   6, 0, 0);
        addVec("nosectick",  0,  0, 59,  0, 0,  0, 1,   6, 0, 0);
        addVec("ldhr23",     0,  0,  0,  1, 1, 23, 1,   6,23, 0);
        addVec("ldmin59",    0,  0,  0,  1, 0, 59, 1,  59,23, 0);
        addVec("midnight",   0,  1, 59,  0, 0,  0, 1,   0, 0, 1);
        addVec("aftermid",   0,  0,  0,  0, 0,  0, 1,   0, 0, 0);
        addVec("ldhr24",     0,  0,  0,  1, 1, 24, 1,   0, 0, 0);
        addVec("ldhrbit5",   0,  0,  0,  1, 1, 41, 1,   0, 0, 0);
        addVec("ldhr3",      0,  0,  0,  1, 1,  3, 1,   0, 3, 0);
        addVec("ldmin60",    0,  0,  0,  1, 0, 60, 1,   0, 3, 0);
        addVec("ldmin59b",   0,  0,  0,  1, 0, 59, 1,  59, 3, 0);
        addVec("ldhr9cin",   0,  1, 59,  1, 1,  9, 1,  59, 9, 0);
        addVec("hrcarry",    0,  1, 59,  0, 0,  0, 1,   0,10, 0);
        addVec("h12_11",     0,  0,  0,  1, 1, 11, 1,   0,11, 0);
        addVec("h12_12",     0,  0,  0,  1, 1, 12, 1,   0,12, 0);
        addVec("h12_23",     0,  0,  0,  1, 1, 23, 1,   0,23, 0);
        addVec("h12_0",      0,  0,  0,  1, 1,  0, 1,   0, 0, 0);
        addVec("ldhr23b",    0,  0,  0,  1, 1, 23, 1,   0,23, 0);
        addVec("ldmin59c",   0,  0,  0,  1, 0, 59, 1,  59,23, 0);
        addVec("badldcin",   0,  1, 59,  1, 0, 61, 1,  59,23, 0);
        addVec("noDcAfter",  0,  0,  0,  0, 0,  0, 1,  59,23, 0);
        addVec("ldmin42",    0,  0,  0,  1, 0, 42, 0,  42,23, 0);
        addVec("ldhr7gate0", 0,  0,  0,  1, 1,  7, 0,  42, 7, 0);
        addVec("gate1",      0,  0,  0,  0, 0,  0, 1,  42, 7, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].tck, vecs[i].sc, vecs[i].ld,
                          vecs[i].sel, vecs[i].dat, vecs[i].en);
            checkOutput(vecs[i].name, vecs[i].expMin, vecs[i].expHour, vecs[i].expDc);
        end

        // Clear landing on the same edge as a midnight rollover must not pulse.
        applyStimulus(0, 0, 0, 1, 1, 23, 1);
        applyStimulus(0, 0, 0, 1, 0, 59, 1);
        checkOutput("pre_clrmid", 59, 23, 0);
        applyStimulus(1, 1, 59, 0, 0, 0, 1);
        checkOutput("clrmid", 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("clrmid_next", 0, 0, 0);

        // Carry pulse lasts exactly one cycle even with ticks continuing.
        applyStimulus(0, 0, 0, 1, 1, 23, 1);
        applyStimulus(0, 0, 0, 1, 0, 59, 1);
        applyStimulus(0, 1, 59, 0, 0, 0, 1);
        checkOutput("mid2", 0, 0, 1);
        applyStimulus(0, 1, 59, 0, 0, 0, 1);
        checkOutput("mid2_next", 1, 0, 0);

        // Randomised run against the minutes-of-day model, starting near midnight.
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        modelStep(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 23, 1);
        modelStep(0, 0, 0, 1, 1, 23);
        applyStimulus(0, 0, 0, 1, 0, 40, 1);
        modelStep(0, 0, 0, 1, 0, 40);
        for (int n = 0; n < 600; n++) begin
            bit        rClr, rTck, rLd, rSel, rEn;
            bit [5:0]  rSec, rDat;
            rClr = ($urandom_range(0, 99) == 0);
            rTck = ($urandom_range(0, 3) != 0);
            rSec = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'd59;
            rLd  = ($urandom_range(0, 9) == 0);
            rSel = 1'($urandom_range(0, 1));
            rDat = 6'($urandom_range(0, 63));
            rEn  = ($urandom_range(0, 4) != 0);
            applyStimulus(rClr, rTck, rSec, rLd, rSel, rDat, rEn);
            modelStep(rClr, rTck, rSec, rLd, rSel, rDat);
            checkOutput($sformatf("rand%0d", n), modelT % 60, modelT / 60, modelDc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
